// File: rtl/gt_rx_pkg.sv
// Shared GT RX definitions: capture FSM states and channel geometry common with the TX side.
package gt_rx_pkg;
  localparam int GT_RX_CHN_NUM    = 6;
  localparam int GT_RX_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } cap_state_e;
endpackage

// File: rtl/gt_rx_capture_ram.sv
// Capture buffer: one write port and one registered read-first read port, block-RAM style.
module gt_rx_capture_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register samples the pre-write contents, so same-address collisions return old data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else        rdata <= mem[raddr];
  end
endmodule

// File: rtl/gt_rx_capture.sv
// Captures one selected GT RX channel into a buffer, triggered by a sync word, with ARM timeout.
module gt_rx_capture
  import gt_rx_pkg::*;
#(
  parameter int CHN_NUM    = GT_RX_CHN_NUM,
  parameter int DATA_WIDTH = GT_RX_DATA_WIDTH,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                          gt_clk,
  input  logic                          gt_rstb,
  input  logic [CHN_NUM*DATA_WIDTH-1:0] rx_data,
  input  logic [CHN_NUM-1:0]            rx_valid,
  input  logic                          reg_start,
  input  logic                          reg_reset,
  input  logic [2:0]                    chn_sel,
  input  logic [DATA_WIDTH-1:0]         sync_word,
  input  logic [ADDR_WIDTH:0]           cap_len,
  input  logic [31:0]                   timeout,
  input  logic [ADDR_WIDTH-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          cap_busy,
  output logic                          cap_done,
  output logic                          cap_timeout,
  output logic [ADDR_WIDTH:0]           word_cnt
);
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE_L   = (ADDR_WIDTH+1)'(1);

  cap_state_e state, state_nxt;

  logic                  start_d;
  logic                  start_edge;
  logic                  accept;
  logic [2:0]            sel_q;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH:0]   len_eff;
  logic [31:0]           to_q;
  logic [31:0]           to_cnt;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_vld;
  logic                  hit;
  logic                  cap_wr;
  logic                  to_exp;
  logic [ADDR_WIDTH:0]   wc_inc;
  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic                  done_set;
  logic                  to_set;

  assign start_edge = reg_start & ~start_d;
  assign accept     = start_edge && !reg_reset && (state == IDLE || state == DONE);
  assign len_eff    = (cap_len == '0 || cap_len > DEPTH_L) ? DEPTH_L : cap_len;
  assign wc_inc     = word_cnt + ONE_L;

  // Out-of-range selections (6, 7) never see valid data.
  always_comb begin
    sel_data = '0;
    sel_vld  = 1'b0;
    for (int k = 0; k < CHN_NUM; k++) begin
      if (sel_q == 3'(k)) begin
        sel_data = rx_data[k*DATA_WIDTH +: DATA_WIDTH];
        sel_vld  = rx_valid[k];
      end
    end
  end

  assign hit    = (state == ARM) && sel_vld && (sel_data == sync_word);
  assign cap_wr = (state == CAPTURE) && sel_vld;
  assign to_exp = (state == ARM) && !hit && (to_q != '0) && (to_cnt + 32'd1 == to_q);

  always_ff @(posedge gt_clk or negedge gt_rstb) begin
    if (!gt_rstb) begin
      state    <= IDLE;
      cap_busy <= 1'b0;
    end else begin
      state    <= state_nxt;
      cap_busy <= (state_nxt == ARM) || (state_nxt == CAPTURE);
    end
  end

  always_comb begin
    state_nxt = state;
    if (reg_reset) state_nxt = IDLE;
    else begin
      case (state)
        IDLE, DONE: if (start_edge) state_nxt = ARM;
        ARM: begin
          if (hit)         state_nxt = (len_q == ONE_L) ? DONE : CAPTURE;
          else if (to_exp) state_nxt = DONE;
        end
        CAPTURE: if (cap_wr && wc_inc == len_q) state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    we       = !reg_reset && (hit || cap_wr);
    waddr    = hit ? '0 : word_cnt[ADDR_WIDTH-1:0];
    done_set = !reg_reset && ((hit && len_q == ONE_L) || (cap_wr && wc_inc == len_q));
    to_set   = !reg_reset && to_exp;
  end

  always_ff @(posedge gt_clk or negedge gt_rstb) begin
    if (!gt_rstb) begin
      start_d <= 1'b0;
      sel_q   <= '0;
      len_q   <= '0;
      to_q    <= '0;
      to_cnt  <= '0;
    end else begin
      start_d <= reg_start;
      if (accept) begin
        sel_q  <= chn_sel;
        len_q  <= len_eff;
        to_q   <= timeout;
        to_cnt <= '0;
      end else if (state == ARM && !hit) begin
        to_cnt <= to_cnt + 32'd1;
      end
    end
  end

  always_ff @(posedge gt_clk or negedge gt_rstb) begin
    if (!gt_rstb) begin
      word_cnt    <= '0;
      cap_done    <= 1'b0;
      cap_timeout <= 1'b0;
    end else if (reg_reset || accept) begin
      word_cnt    <= '0;
      cap_done    <= 1'b0;
      cap_timeout <= 1'b0;
    end else begin
      if (we)       word_cnt    <= hit ? ONE_L : wc_inc;
      if (done_set) cap_done    <= 1'b1;
      if (to_set)   cap_timeout <= 1'b1;
    end
  end

  gt_rx_capture_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (gt_clk),
    .rst_n (gt_rstb),
    .we    (we),
    .waddr (waddr),
    .wdata (sel_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );
endmodule

// File: tb/tb_gt_rx_capture.sv
// Directed bench for gt_rx_capture: trigger, gaps, timeout, full-depth, soft reset, channel latch.
module tb_gt_rx_capture;
  localparam int CHN = 6;
  localparam int DW  = 32;
  localparam int DEP = 1024;
  localparam int AW  = 10;
  localparam logic [DW-1:0] SYNC = 32'hBCBC50C5;

  logic              gt_clk = 1'b0;
  logic              gt_rstb;
  logic [CHN*DW-1:0] rx_data;
  logic [CHN-1:0]    rx_valid;
  logic              reg_start, reg_reset;
  logic [2:0]        chn_sel;
  logic [DW-1:0]     sync_word;
  logic [AW:0]       cap_len;
  logic [31:0]       timeout;
  logic [AW-1:0]     rd_addr;
  logic [DW-1:0]     rd_data;
  logic              cap_busy, cap_done, cap_timeout;
  logic [AW:0]       word_cnt;

  int checks = 0;
  int errors = 0;

  always #5 gt_clk = ~gt_clk;

  gt_rx_capture #(.CHN_NUM(CHN), .DATA_WIDTH(DW), .DEPTH(DEP)) dut (
    .gt_clk(gt_clk), .gt_rstb(gt_rstb), .rx_data(rx_data), .rx_valid(rx_valid),
    .reg_start(reg_start), .reg_reset(reg_reset), .chn_sel(chn_sel),
    .sync_word(sync_word), .cap_len(cap_len), .timeout(timeout),
    .rd_addr(rd_addr), .rd_data(rd_data), .cap_busy(cap_busy),
    .cap_done(cap_done), .cap_timeout(cap_timeout), .word_cnt(word_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge gt_clk);
    #1;
  endtask

  // Present one word on channel ch for one cycle; returns just after the sampling edge.
  task automatic send(input int ch, input logic [DW-1:0] d, input bit vld);
    rx_data  = '0;
    rx_data[ch*DW +: DW] = d;
    rx_valid = vld ? CHN'(1 << ch) : '0;
    step();
    rx_valid = '0;
  endtask

  task automatic start();
    reg_start = 1'b1;
    step();
    reg_start = 1'b0;
  endtask

  task automatic rd(input int a, output logic [DW-1:0] d);
    rd_addr = AW'(a);
    step();
    d = rd_data;
  endtask

  task automatic sweep(input string tag, input logic [DW-1:0] exp [4]);
    logic [DW-1:0] d;
    for (int i = 0; i < 4; i++) begin
      rd(i, d);
      chk($sformatf("%s[%0d]", tag, i), d, exp[i]);
    end
  endtask

  initial begin
    logic [DW-1:0] d;
    gt_rstb = 1'b0; rx_data = '0; rx_valid = '0; reg_start = 0; reg_reset = 0;
    chn_sel = 3'd2; sync_word = SYNC; cap_len = 11'd4; timeout = 0; rd_addr = '0;
    repeat (3) @(posedge gt_clk);
    #1 gt_rstb = 1'b1;
    chk("rst_busy", cap_busy, 0);
    chk("rst_done", cap_done, 0);
    chk("rst_to", cap_timeout, 0);
    chk("rst_wcnt", word_cnt, 0);
    chk("rst_rdata", rd_data, 0);

    // Basic capture of four words on channel 2
    start();
    chk("t1_busy", cap_busy, 1);
    send(1, SYNC, 1);
    chk("t1_other_ch", word_cnt, 0);
    send(2, SYNC, 1);
    chk("t1_wcnt1", word_cnt, 1);
    send(2, 32'h1, 1);
    send(2, 32'h2, 1);
    chk("t1_wcnt3", word_cnt, 3);
    chk("t1_notdone", cap_done, 0);
    send(2, 32'h3, 1);
    chk("t1_done", cap_done, 1);
    chk("t1_wcnt4", word_cnt, 4);
    chk("t1_idle", cap_busy, 0);
    send(2, 32'h99, 1);
    chk("t1_hold", word_cnt, 4);
    sweep("t1_buf", '{SYNC, 32'h1, 32'h2, 32'h3});

    // Gapped valid with the sync word repeated as data
    start();
    chk("t2_clr_done", cap_done, 0);
    chk("t2_clr_wcnt", word_cnt, 0);
    send(2, SYNC, 1);
    send(2, 32'hDEAD, 0);
    send(2, 32'hA, 1);
    send(2, 32'hDEAD, 0);
    send(2, SYNC, 1);
    send(2, 32'hDEAD, 0);
    chk("t2_wcnt3", word_cnt, 3);
    send(2, 32'hB, 1);
    chk("t2_done", cap_done, 1);
    chk("t2_wcnt4", word_cnt, 4);
    sweep("t2_buf", '{SYNC, 32'hA, SYNC, 32'hB});

    // ARM timeout of 100 cycles
    timeout = 100;
    start();
    repeat (99) step();
    chk("t3_busy99", cap_busy, 1);
    chk("t3_to99", cap_timeout, 0);
    step();
    chk("t3_busy100", cap_busy, 0);
    chk("t3_to100", cap_timeout, 1);
    chk("t3_done", cap_done, 0);
    timeout = 0;

    // cap_len = 1 completes on the sync word itself
    cap_len = 11'd1;
    start();
    chk("t4_to_clr", cap_timeout, 0);
    send(2, SYNC, 1);
    chk("t4_done", cap_done, 1);
    chk("t4_wcnt", word_cnt, 1);

    // cap_len = 0 means full depth; extra valid words must not wrap to address 0
    cap_len = 11'd0;
    start();
    send(2, SYNC, 1);
    for (int i = 1; i < DEP; i++) send(2, DW'(i), 1);
    chk("t5_done", cap_done, 1);
    chk("t5_wcnt", word_cnt, 11'd1024);
    send(2, 32'hFFFF, 1);
    send(2, 32'hFFFF, 1);
    chk("t5_wcnt_hold", word_cnt, 11'd1024);
    rd(0, d);    chk("t5_a0", d, SYNC);
    rd(1, d);    chk("t5_a1", d, 32'h1);
    rd(1023, d); chk("t5_a1023", d, 32'd1023);

    // Soft reset in CAPTURE at word_cnt = 5, with a valid word in the same cycle
    cap_len = 11'd10;
    start();
    send(2, SYNC, 1);
    for (int i = 0; i < 4; i++) send(2, 32'd100 + 32'(i), 1);
    chk("t6_wcnt5", word_cnt, 5);
    reg_reset = 1'b1;
    send(2, 32'h55, 1);
    reg_reset = 1'b0;
    chk("t6_busy", cap_busy, 0);
    chk("t6_wcnt", word_cnt, 0);
    chk("t6_done", cap_done, 0);
    rd(0, d); chk("t6_a0", d, SYNC);
    rd(4, d); chk("t6_a4", d, 32'd103);
    rd(5, d); chk("t6_a5_nowrite", d, 32'd5);
    reg_start = 1'b1; reg_reset = 1'b1;
    step();
    reg_reset = 1'b0;
    chk("t6_rst_wins", cap_busy, 0);
    step();
    chk("t6_no_edge", cap_busy, 0);
    reg_start = 1'b0;
    step();

    // Channel selection is latched at start; a start edge while armed is ignored
    chn_sel = 3'd2; cap_len = 11'd4;
    start();
    send(3, SYNC, 1);
    chk("t7_ch3_ignored", word_cnt, 0);
    chn_sel = 3'd3;
    send(3, SYNC, 1);
    chk("t7_latched", word_cnt, 0);
    start();
    send(3, SYNC, 1);
    chk("t7_restart_ign", word_cnt, 0);
    chk("t7_busy", cap_busy, 1);
    send(2, SYNC, 1);
    chk("t7_ch2_trig", word_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
